invk2j_cordic: RTL and testbench

INVK2J_CORDIC -- requirements
Module: invk2j_cordic

---
 rtl/invk2j_cordic.sv | 165 ++++++++++++++++
 tb/tb_invk2j_cordic.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/invk2j_cordic.sv
// Vectoring-mode CORDIC: converts a signed (x,y) vector into atan2 angle and
// gain-scaled magnitude, one micro-rotation per clock, with a ready/valid handshake.
module invk2j_cordic #(
    parameter int W    = 16,
    parameter int ITER = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] out_ang,
    output logic        [W:0]   out_mag,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int XW = W + 2;
    localparam int CW = $clog2(ITER + 1);
    localparam int SH = 32 - W;
    localparam logic [32:0] HALF = (SH == 0) ? 33'd0 : (33'd1 << (SH - 1));
    localparam logic signed [W-1:0] QUARTER = {2'b01, {(W-2){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic signed [W-1:0]   r_z;
    logic                  r_zero;
    logic signed [W-1:0]   r_ang;
    logic        [W:0]     r_mag;

    logic signed [XW-1:0]  w_xSx;
    logic signed [XW-1:0]  w_ySx;
    logic signed [XW-1:0]  w_xShift;
    logic signed [XW-1:0]  w_yShift;
    logic signed [XW-1:0]  w_xNext;
    logic signed [XW-1:0]  w_yNext;
    logic signed [W-1:0]   w_zNext;
    logic signed [W-1:0]   w_step;

    // atan(2^-i) in units of pi/2^31
    function automatic logic [31:0] atanFull(input logic [5:0] idx);
        case (idx)
            6'd0:  return 32'd536870912;
            6'd1:  return 32'd316933406;
            6'd2:  return 32'd167458907;
            6'd3:  return 32'd85004756;
            6'd4:  return 32'd42667331;
            6'd5:  return 32'd21354465;
            6'd6:  return 32'd10679838;
            6'd7:  return 32'd5340245;
            6'd8:  return 32'd2670163;
            6'd9:  return 32'd1335087;
            6'd10: return 32'd667544;
            6'd11: return 32'd333772;
            6'd12: return 32'd166886;
            6'd13: return 32'd83443;
            6'd14: return 32'd41722;
            6'd15: return 32'd20861;
            6'd16: return 32'd10430;
            6'd17: return 32'd5215;
            6'd18: return 32'd2608;
            6'd19: return 32'd1304;
            6'd20: return 32'd652;
            6'd21: return 32'd326;
            6'd22: return 32'd163;
            6'd23: return 32'd81;
            6'd24: return 32'd41;
            6'd25: return 32'd20;
            6'd26: return 32'd10;
            6'd27: return 32'd5;
            6'd28: return 32'd3;
            6'd29: return 32'd1;
            6'd30: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic signed [W-1:0] atanStep(input logic [5:0] idx);
        logic [32:0] rounded;
        rounded = ({1'b0, atanFull(idx)} + HALF) >> SH;
        return rounded[W-1:0];
    endfunction

    assign w_xSx     = {{2{in_x[W-1]}}, in_x};
    assign w_ySx     = {{2{in_y[W-1]}}, in_y};
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign out_ang   = r_ang;
    assign out_mag   = r_mag;

    // Rotate toward y=0; x and y both update from the pre-rotation values
    always_comb begin
        w_xShift = r_x >>> r_cnt;
        w_yShift = r_y >>> r_cnt;
        w_step   = atanStep(6'(r_cnt));
        if (!r_y[XW-1]) begin
            w_xNext = r_x + w_yShift;
            w_yNext = r_y - w_xShift;
            w_zNext = r_z + w_step;
        end else begin
            w_xNext = r_x - w_yShift;
            w_yNext = r_y + w_xShift;
            w_zNext = r_z - w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_ang   <= '0;
            r_mag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cnt  <= '0;
                        r_zero <= (in_x == '0) && (in_y == '0);
                        // Left half-plane vectors are turned by +/-90 deg first
                        if (in_x[W-1] && !in_y[W-1]) begin
                            r_x <= w_ySx;
                            r_y <= -w_xSx;
                            r_z <= QUARTER;
                        end else if (in_x[W-1]) begin
                            r_x <= -w_ySx;
                            r_y <= w_xSx;
                            r_z <= -QUARTER;
                        end else begin
                            r_x <= w_xSx;
                            r_y <= w_ySx;
                            r_z <= '0;
                        end
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (r_cnt == CW'(ITER)) begin
                        r_ang   <= r_zero ? '0 : r_z;
                        r_mag   <= r_zero ? '0 : r_x[W:0];
                        r_state <= ST_DONE;
                    end else begin
                        r_x   <= w_xNext;
                        r_y   <= w_yNext;
                        r_z   <= w_zNext;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_invk2j_cordic.sv
// Self-checking bench for invk2j_cordic: directed vectors, hold/abort behaviour,
// and randomized handshaking against a real-arithmetic atan2/magnitude model.
module tb_invk2j_cordic;

    localparam int  W         = 16;
    localparam int  ITER      = 14;
    localparam real PI        = 3.14159265358979323846;
    localparam real ANG_SCALE = 32768.0 / PI;
    localparam int  MAG_TOL   = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] in_x = '0;
    logic signed [W-1:0] in_y = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] out_ang;
    logic        [W:0]   out_mag;
    logic                out_valid;
    logic                out_ready = 1'b0;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    invk2j_cordic #(.W(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ang   (out_ang),
        .out_mag   (out_mag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic real gainK();
        real k = 1.0;
        real p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p * 0.25;
        end
        return k;
    endfunction

    function automatic int refAng(input int x, input int y);
        real a;
        int  r;
        if (x == 0 && y == 0) return 0;
        a = $atan2(real'(y), real'(x)) * ANG_SCALE;
        r = (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(a - 0.5);
        if (r >= 32768) r -= 65536;
        return r;
    endfunction

    function automatic int refMag(input int x, input int y);
        return $rtoi(gainK() * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) + 0.5);
    endfunction

    // y is resolved to one integer LSB, so angle error grows as magnitude shrinks
    function automatic int angTol(input int mag);
        if (mag == 0) return 0;
        return 3 + $rtoi(3.0 * ANG_SCALE / real'(mag));
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp,
                               input int tol, input bit wrap);
        longint              d;
        logic signed [W-1:0] d16;
        bit                  ok;
        testCount++;
        if (wrap) begin
            d16 = W'(obs - exp);
            d   = d16;
        end else begin
            d = obs - exp;
        end
        ok = (d <= tol) && (d >= -tol);
        assert (ok === 1'b1) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, output int latency);
        int waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("in_ready before accept", longint'(in_ready), 1, 0, 1'b0);
        in_x     = W'(x);
        in_y     = W'(y);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = 16'sh1234;
        in_y     = -16'sh0777;
        latency  = 0;
        while (!out_valid && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic runDirected(input string tag, input int x, input int y);
        int lat;
        int eA;
        int eM;
        eA = refAng(x, y);
        eM = refMag(x, y);
        applyStimulus(x, y, lat);
        checkOutput({tag, " latency"}, lat, ITER + 1, 0, 1'b0);
        checkOutput({tag, " ang"}, longint'(out_ang), eA, angTol(eM), 1'b1);
        checkOutput({tag, " mag"}, longint'(out_mag), eM, (eM == 0) ? 0 : MAG_TOL, 1'b0);
        releaseResult();
    endtask

    initial begin
        int lat;
        int eA;
        int eM;
        bit seen;
        int vx[10];
        int vy[10];
        int qA[$];
        int qM[$];
        int sent;
        int got;
        int extra;
        int cyc;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", longint'(in_ready), 0, 0, 1'b0);
        checkOutput("reset out_valid", longint'(out_valid), 0, 0, 1'b0);
        checkOutput("reset ang", longint'(out_ang), 0, 0, 1'b0);
        checkOutput("reset mag", longint'(out_mag), 0, 0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", longint'(in_ready), 1, 0, 1'b0);

        // Directed vectors
        runDirected("(1000,0)", 1000, 0);
        runDirected("(0,1000)", 0, 1000);
        runDirected("(-1000,0)", -1000, 0);
        runDirected("(-1000,-1000)", -1000, -1000);
        runDirected("(0,0)", 0, 0);
        runDirected("(-32768,-32768)", -32768, -32768);
        runDirected("(0,-32768)", 0, -32768);
        runDirected("(32767,32767)", 32767, 32767);

        // Hold in DONE with out_ready low; inputs must be ignored
        eA = refAng(3000, -2000);
        eM = refMag(3000, -2000);
        applyStimulus(3000, -2000, lat);
        in_x     = -16'sd5;
        in_y     = 16'sd7;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("hold out_valid", longint'(out_valid), 1, 0, 1'b0);
            checkOutput("hold in_ready", longint'(in_ready), 0, 0, 1'b0);
            checkOutput("hold ang", longint'(out_ang), eA, angTol(eM), 1'b1);
            checkOutput("hold mag", longint'(out_mag), eM, MAG_TOL, 1'b0);
        end
        out_ready = 1'b1;
        checkOutput("release in_ready", longint'(in_ready), 0, 0, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("post-release out_valid", longint'(out_valid), 0, 0, 1'b0);
        checkOutput("post-release in_ready", longint'(in_ready), 1, 0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("no accept on release", longint'(in_ready), 1, 0, 1'b0);

        // Abort with reset mid-iteration
        @(negedge clk);
        in_x     = 16'sd12000;
        in_y     = 16'sd9000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("in_ready during rst", longint'(in_ready), 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort ang", longint'(out_ang), 0, 0, 1'b0);
        checkOutput("abort mag", longint'(out_mag), 0, 0, 1'b0);
        checkOutput("abort out_valid", longint'(out_valid), 0, 0, 1'b0);
        checkOutput("abort in_ready", longint'(in_ready), 1, 0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("no valid after abort", longint'(seen), 0, 0, 1'b0);
        runDirected("(5000,7000)", 5000, 7000);

        // Randomized vectors with random in_valid/out_ready
        for (int i = 0; i < 10; i++) begin
            do begin
                vx[i] = int'($urandom_range(0, 65535)) - 32768;
                vy[i] = int'($urandom_range(0, 65535)) - 32768;
            end while (((vx[i] < 0) ? -vx[i] : vx[i]) < 4096 &&
                       ((vy[i] < 0) ? -vy[i] : vy[i]) < 4096);
        end
        sent  = 0;
        got   = 0;
        extra = 0;
        cyc   = 0;
        while (got < 10 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 10) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            if (sent < 10) begin
                in_x = W'(vx[sent]);
                in_y = W'(vy[sent]);
            end
            if (in_valid && in_ready) begin
                qA.push_back(refAng(vx[sent], vy[sent]));
                qM.push_back(refMag(vx[sent], vy[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (qA.size() == 0) begin
                    extra++;
                end else begin
                    eA = qA.pop_front();
                    eM = qM.pop_front();
                    checkOutput("random ang", longint'(out_ang), eA, angTol(eM), 1'b1);
                    checkOutput("random mag", longint'(out_mag), eM, MAG_TOL, 1'b0);
                    got++;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("random results received", got, 10, 0, 1'b0);
        checkOutput("random duplicates", extra, 0, 0, 1'b0);
        checkOutput("random pending", qA.size(), 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
